// File: rtl/merge_rr_arbiter.sv
// Fair N-to-1 merge: round-robin grant among valid inputs into a one-slot
// registered output that carries the winning channel index.
module merge_rr_arbiter #(
  parameter int INPUTS      = 2,
  parameter int DATA_TYPE   = 32,
  parameter int INDEX_WIDTH = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [INPUTS*DATA_TYPE-1:0] ins,
  input  logic [INPUTS-1:0]           ins_valid,
  output logic [INPUTS-1:0]           ins_ready,
  output logic [DATA_TYPE-1:0]        outs,
  output logic [INDEX_WIDTH-1:0]      outs_index,
  output logic                        outs_valid,
  input  logic                        outs_ready
);

  localparam logic [INDEX_WIDTH-1:0] LAST = INDEX_WIDTH'(INPUTS - 1);

  logic [INDEX_WIDTH-1:0] ptr;
  logic [DATA_TYPE-1:0]   data_p1;
  logic [INDEX_WIDTH-1:0] idx_p1;
  logic                   vld_p1;

  logic                   load;
  logic                   xfer;
  logic                   gnt_any;
  logic                   hi_found;
  logic                   lo_found;
  logic [INDEX_WIDTH-1:0] hi_idx;
  logic [INDEX_WIDTH-1:0] lo_idx;
  logic [INDEX_WIDTH-1:0] gnt_idx;
  logic [DATA_TYPE-1:0]   gnt_data;

  function automatic logic [INDEX_WIDTH-1:0] next_ptr(input logic [INDEX_WIDTH-1:0] g);
    return (g == LAST) ? '0 : g + 1'b1;
  endfunction

  // Two-pass search: first valid channel at or above ptr, else the lowest valid one.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = 0; i < INPUTS; i++) begin
      if (ins_valid[i] && !hi_found && (INDEX_WIDTH'(i) >= ptr)) begin
        hi_found = 1'b1;
        hi_idx   = INDEX_WIDTH'(i);
      end
      if (ins_valid[i] && !lo_found) begin
        lo_found = 1'b1;
        lo_idx   = INDEX_WIDTH'(i);
      end
    end
    gnt_idx = hi_found ? hi_idx : lo_idx;
    gnt_any = hi_found || lo_found;
  end

  assign load = !vld_p1 || outs_ready;
  // Ready is held low during reset so no producer believes a token was taken.
  assign xfer = gnt_any && load && !rst;

  always_comb begin
    ins_ready = '0;
    gnt_data  = '0;
    for (int i = 0; i < INPUTS; i++) begin
      if (gnt_idx == INDEX_WIDTH'(i)) begin
        ins_ready[i] = xfer;
        gnt_data     = ins[i*DATA_TYPE +: DATA_TYPE];
      end
    end
  end

  // ---- stage p1: output slot and priority pointer ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      idx_p1  <= '0;
      ptr     <= '0;
    end else if (xfer) begin
      vld_p1  <= 1'b1;
      data_p1 <= gnt_data;
      idx_p1  <= gnt_idx;
      ptr     <= next_ptr(gnt_idx);
    end else if (outs_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign outs       = data_p1;
  assign outs_index = idx_p1;
  assign outs_valid = vld_p1;

endmodule
